// File: rtl/instr_fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   fetch_state_t : sequencer state (idle, running a program, halted)
//   *_DEF         : default widths used by the sequencer and its branch LUT
package instr_fetch_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } fetch_state_t;

  localparam int PC_W_DEF      = 10;
  localparam int LUT_IDX_W_DEF = 5;
  localparam int CNT_W_DEF     = 16;

endpackage

// File: rtl/instr_fetch_seq_branch_lut.sv
// Branch-target lookup: maps the immediate index of a B/BTRU instruction
// to an absolute program counter. Purely combinational ROM whose contents
// are fixed at elaboration through LUT_INIT (entry i at bits [i*PC_W +: PC_W]).
//   idx_i    : LUT index from the current instruction
//   target_o : branch target PC
module instr_fetch_seq_branch_lut
  import instr_fetch_seq_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int LUT_IDX_W = LUT_IDX_W_DEF,
  parameter logic [(2**LUT_IDX_W)*PC_W-1:0] LUT_INIT = '0
) (
  input  logic [LUT_IDX_W-1:0] idx_i,
  output logic [PC_W-1:0]      target_o
);

  localparam int DEPTH = 2**LUT_IDX_W;

  logic [PC_W-1:0] lut_mem [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign lut_mem[gi] = LUT_INIT[gi*PC_W +: PC_W];
  end

  assign target_o = lut_mem[idx_i];

endmodule

// File: rtl/instr_fetch_seq.sv
// Program-counter sequencer feeding the instruction ROM. Launches a program
// on Start, advances/branches the PC from Control's decode of the current
// word, stops on Halt or when the PC runs off the end of the ROM, and counts
// executed cycles (saturating).
//   Clk, Reset          : clock, synchronous active-high reset
//   Start               : launch program from idle or halted
//   Halt/Branch/Taken   : Control decode of the word at Prog_Ctr (used in RUN only)
//   Target_Idx          : branch LUT index of the current word
//   Prog_Ctr            : registered ROM address
//   Run / Done          : state is RUN / HALTED
//   Fault               : sticky, PC reached the last ROM word without branching/halting
//   Cycle_Cnt           : executed cycles of the last/current run, saturating
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter int              LUT_IDX_W  = LUT_IDX_W_DEF,
  parameter int              CNT_W      = CNT_W_DEF,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter logic [(2**LUT_IDX_W)*PC_W-1:0] LUT_INIT = '0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Halt,
  input  logic                 Branch,
  input  logic                 Taken,
  input  logic [LUT_IDX_W-1:0] Target_Idx,
  output logic [PC_W-1:0]      Prog_Ctr,
  output logic                 Run,
  output logic                 Done,
  output logic                 Fault,
  output logic [CNT_W-1:0]     Cycle_Cnt
);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic [PC_W-1:0]  branch_target;

  instr_fetch_seq_branch_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W),
    .LUT_INIT  (LUT_INIT)
  ) u_branch_lut (
    .idx_i    (Target_Idx),
    .target_o (branch_target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (Start) begin
          state_d = S_RUN;
          pc_d    = START_ADDR;
          cnt_d   = '0;
          fault_d = 1'b0;
        end
      end
      S_RUN: begin
        // Counts every RUN cycle, including the one that halts.
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (Halt) begin
          // PC stays on the HALT word.
          state_d = S_HALTED;
        end else if (Branch && Taken) begin
          pc_d = branch_target;
        end else if (pc_q == '1) begin
          // Last ROM word with no jump: stop rather than wrap to 0.
          state_d = S_HALTED;
          fault_d = 1'b1;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign Prog_Ctr  = pc_q;
  assign Run       = (state_q == S_RUN);
  assign Done      = (state_q == S_HALTED);
  assign Fault     = fault_q;
  assign Cycle_Cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
module tb_instr_fetch_seq;

  localparam int IW = 5;

  // Branch tables: entry i -> i*10 (10-bit PC), entry i -> (3*i+1) mod 16 (4-bit PC).
  function automatic logic [32*10-1:0] mk_lut_a();
    logic [32*10-1:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[i*10 +: 10] = 10'((i * 10) % 1024);
    return v;
  endfunction

  function automatic logic [32*4-1:0] mk_lut_b();
    logic [32*4-1:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[i*4 +: 4] = 4'((3 * i + 1) % 16);
    return v;
  endfunction

  localparam logic [32*10-1:0] LUT_A = mk_lut_a();
  localparam logic [32*4-1:0]  LUT_B = mk_lut_b();

  logic          Clk = 1'b0;
  logic          Reset, Start, Halt, Branch, Taken;
  logic [IW-1:0] Target_Idx;

  logic [9:0]  pc_a;  logic run_a, done_a, fault_a;  logic [15:0] cnt_a;
  logic [3:0]  pc_b;  logic run_b, done_b, fault_b;  logic [2:0]  cnt_b;

  always #5 Clk = ~Clk;

  instr_fetch_seq #(
    .PC_W(10), .LUT_IDX_W(IW), .CNT_W(16), .START_ADDR(10'd0), .LUT_INIT(LUT_A)
  ) dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Branch(Branch),
    .Taken(Taken), .Target_Idx(Target_Idx), .Prog_Ctr(pc_a), .Run(run_a),
    .Done(done_a), .Fault(fault_a), .Cycle_Cnt(cnt_a)
  );

  instr_fetch_seq #(
    .PC_W(4), .LUT_IDX_W(IW), .CNT_W(3), .START_ADDR(4'd0), .LUT_INIT(LUT_B)
  ) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Branch(Branch),
    .Taken(Taken), .Target_Idx(Target_Idx), .Prog_Ctr(pc_b), .Run(run_b),
    .Done(done_b), .Fault(fault_b), .Cycle_Cnt(cnt_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model, one slot per DUT: 0 = 10-bit PC / 16-bit count, 1 = 4-bit PC / 3-bit count.
  int rom_words [2] = '{1024, 16};
  int cnt_max   [2] = '{65535, 7};
  bit m_running [2];
  bit m_halted  [2];
  bit m_fault   [2];
  int m_pc      [2];
  int m_cnt     [2];

  function automatic int lut_model(int d, int idx);
    return (d == 0) ? (idx * 10) % 1024 : (3 * idx + 1) % 16;
  endfunction

  task automatic model_step(input int d);
    if (Reset) begin
      m_running[d] = 0; m_halted[d] = 0; m_fault[d] = 0; m_pc[d] = 0; m_cnt[d] = 0;
    end else if (m_running[d]) begin
      if (m_cnt[d] < cnt_max[d]) m_cnt[d]++;
      if (Halt) begin
        m_running[d] = 0; m_halted[d] = 1;
      end else if (Branch && Taken) begin
        m_pc[d] = lut_model(d, int'(Target_Idx));
      end else if (m_pc[d] == rom_words[d] - 1) begin
        m_running[d] = 0; m_halted[d] = 1; m_fault[d] = 1;
      end else begin
        m_pc[d]++;
      end
    end else if (Start) begin
      m_running[d] = 1; m_halted[d] = 0; m_fault[d] = 0; m_pc[d] = 0; m_cnt[d] = 0;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step(0);
    model_step(1);
    #1;
    chk("a_pc",    32'(pc_a),    32'(m_pc[0]));
    chk("a_run",   32'(run_a),   32'(m_running[0]));
    chk("a_done",  32'(done_a),  32'(m_halted[0]));
    chk("a_fault", 32'(fault_a), 32'(m_fault[0]));
    chk("a_cnt",   32'(cnt_a),   32'(m_cnt[0]));
    chk("b_pc",    32'(pc_b),    32'(m_pc[1]));
    chk("b_run",   32'(run_b),   32'(m_running[1]));
    chk("b_done",  32'(done_b),  32'(m_halted[1]));
    chk("b_fault", 32'(fault_b), 32'(m_fault[1]));
    chk("b_cnt",   32'(cnt_b),   32'(m_cnt[1]));
  endtask

  task automatic idle_inputs();
    Start = 0; Halt = 0; Branch = 0; Taken = 0; Target_Idx = '0;
  endtask

  initial begin
    Reset = 1; idle_inputs();
    tick(); tick();
    chk("rst_pc", 32'(pc_a), 0);
    chk("rst_run", 32'(run_a), 0);
    chk("rst_done", 32'(done_a), 0);
    Reset = 0;

    // Run from 0, halt on word 5.
    Start = 1; tick(); Start = 0;
    chk("t2_start_pc", 32'(pc_a), 0);
    chk("t2_start_run", 32'(run_a), 1);
    repeat (5) tick();
    Halt = 1; tick(); Halt = 0;
    chk("t2_done", 32'(done_a), 1);
    chk("t2_pc", 32'(pc_a), 5);
    chk("t2_cnt", 32'(cnt_a), 6);
    tick();
    chk("t2_pc_hold", 32'(pc_a), 5);

    // Taken branch at PC=3 via index 2.
    Start = 1; tick(); Start = 0;
    repeat (3) tick();
    Branch = 1; Taken = 1; Target_Idx = 5'd2; tick();
    chk("t3_taken_pc", 32'(pc_a), 20);
    // Not-taken branch at PC=3 falls through.
    Branch = 0; Taken = 0; Halt = 1; tick(); Halt = 0;
    Start = 1; tick(); Start = 0;
    repeat (3) tick();
    Branch = 1; Taken = 0; tick();
    chk("t3_nt_pc", 32'(pc_a), 4);

    // Halt beats a taken branch.
    Halt = 1; Branch = 1; Taken = 1; Target_Idx = 5'd7; tick(); idle_inputs();
    chk("t4_done", 32'(done_a), 1);
    chk("t4_pc", 32'(pc_a), 4);

    // 4-bit PC runs off the end of the ROM.
    Start = 1; tick(); Start = 0;
    repeat (15) tick();
    chk("t5_pc15_run", 32'(run_b), 1);
    tick();
    chk("t5_done", 32'(done_b), 1);
    chk("t5_fault", 32'(fault_b), 1);
    chk("t5_pc", 32'(pc_b), 15);
    Start = 1; tick();
    chk("t5_re_pc", 32'(pc_b), 0);
    chk("t5_re_fault", 32'(fault_b), 0);
    chk("t5_re_run", 32'(run_b), 1);

    // Start held high during a 10-word run; 3-bit count saturates.
    repeat (9) tick();
    chk("t6_pc", 32'(pc_b), 9);
    Halt = 1; tick(); Halt = 0;
    chk("t6_cnt", 32'(cnt_b), 7);
    chk("t6_done", 32'(done_b), 1);
    tick();
    chk("t6_restart", 32'(run_b), 1);
    Start = 0;

    // Reset mid-run at PC=7, count 7.
    Halt = 1; tick(); Halt = 0;
    Start = 1; tick(); Start = 0;
    repeat (7) tick();
    chk("t1_pre_pc", 32'(pc_a), 7);
    chk("t1_pre_cnt", 32'(cnt_a), 7);
    Reset = 1; tick(); Reset = 0;
    chk("t1_pc", 32'(pc_a), 0);
    chk("t1_run", 32'(run_a), 0);
    chk("t1_cnt", 32'(cnt_a), 0);
    chk("t1_fault", 32'(fault_a), 0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      Reset      = ($urandom_range(0, 99) == 0);
      Start      = ($urandom_range(0, 7) == 0);
      Halt       = ($urandom_range(0, 11) == 0);
      Branch     = ($urandom_range(0, 3) == 0);
      Taken      = 1'($urandom_range(0, 1));
      Target_Idx = 5'($urandom_range(0, 31));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
